// File: rtl/bitwise_and_64bit_pkg.sv
// Shared ALU definitions: the datapath width and the opcode encoding the ALU
// mux decodes to steer operands into the AND unit.
package bitwise_and_64bit_pkg;

    localparam int XLEN    = 64;
    localparam int SLICE_W = 16;

    typedef enum logic [3:0] {
        ALU_OP_ADD = 4'h0,
        ALU_OP_SUB = 4'h1,
        ALU_OP_AND = 4'h2,
        ALU_OP_OR  = 4'h3,
        ALU_OP_XOR = 4'h4,
        ALU_OP_SLL = 4'h5,
        ALU_OP_SRL = 4'h6,
        ALU_OP_SRA = 4'h7
    } alu_op_t;

    // The ALU mux raises the AND unit's in_valid only for this opcode.
    function automatic logic is_and_op(input alu_op_t op);
        return op == ALU_OP_AND;
    endfunction

endpackage

// File: rtl/and_slice16.sv
// One 16-bit lane of the AND unit with its own zero detect, so the global
// zero flag is a short reduction over lanes instead of one wide NOR.
module and_slice16
    import bitwise_and_64bit_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    output logic [SLICE_W-1:0] y,
    output logic               zero
);

    assign y    = a & b;
    assign zero = ~|y;

endmodule

// File: rtl/bitwise_and_64bit.sv
// ALU bitwise AND: same-cycle combinational result plus a registered copy
// (with valid and zero flags) for the EX/MEM boundary.
module bitwise_and_64bit
    import bitwise_and_64bit_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             in_valid,
    output logic [WIDTH-1:0] Out,
    output logic             Zero,
    output logic [WIDTH-1:0] Out_r,
    output logic             Zero_r,
    output logic             out_valid
);

    localparam int NSLICE = WIDTH / SLICE_W;

    logic [NSLICE-1:0] slice_zero;

    generate
        for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
            and_slice16 u_slice (
                .a    (A[gi*SLICE_W +: SLICE_W]),
                .b    (B[gi*SLICE_W +: SLICE_W]),
                .y    (Out[gi*SLICE_W +: SLICE_W]),
                .zero (slice_zero[gi])
            );
        end
    endgenerate

    assign Zero = &slice_zero;

    // Result/flag hold when idle; only the valid bit tracks in_valid every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Out_r     <= '0;
            Zero_r    <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Out_r  <= Out;
                Zero_r <= Zero;
            end
        end
    end

endmodule

// File: tb/tb_bitwise_and_64bit.sv
// Directed self-checking bench for bitwise_and_64bit: combinational AND/zero,
// registered capture/hold, and asynchronous reset behaviour.
module tb_bitwise_and_64bit;

    logic        clk;
    logic        rst;
    logic [63:0] A;
    logic [63:0] B;
    logic        in_valid;
    logic [63:0] Out;
    logic        Zero;
    logic [63:0] Out_r;
    logic        Zero_r;
    logic        out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    bitwise_and_64bit #(.WIDTH(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .in_valid  (in_valid),
        .Out       (Out),
        .Zero      (Zero),
        .Out_r     (Out_r),
        .Zero_r    (Zero_r),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        rst      = 1'b1;
        A        = '0;
        B        = '0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_r",  Out_r,     64'h0);
        check("rst_zero_r", {63'h0, Zero_r},    64'h1);
        check("rst_valid",  {63'h0, out_valid}, 64'h0);

        @(negedge clk);
        rst = 1'b0;

        // Combinational path, zero latency.
        A = 64'hAAAA_BBBB_CCCC_DDDD; B = 64'h1111_2222_3333_4444; #1;
        check("comb_mix",   Out, 64'h0000_2222_0000_4444);
        check("comb_mix_z", {63'h0, Zero}, 64'h0);
        A = 64'hFFFF_FFFF_FFFF_FFFF; B = 64'h0000_0000_0000_0001; #1;
        check("comb_lsb",   Out, 64'h1);
        B = 64'h1111_1111_1111_1111; #1;
        check("comb_ones",  Out, 64'h1111_1111_1111_1111);
        A = 64'hFFFF_FFFF_0000_0000; B = 64'h0000_0000_FFFF_FFFF; #1;
        check("comb_zero",  Out, 64'h0);
        check("comb_zero_z", {63'h0, Zero}, 64'h1);
        A = 64'h8000_0000_0000_0000; B = 64'h8000_0000_0000_0000; #1;
        check("comb_msb",   Out, 64'h8000_0000_0000_0000);
        check("comb_msb_z", {63'h0, Zero}, 64'h0);
        A = 64'h0000_0000_0001_0000; B = 64'hFFFF_FFFF_FFFF_FFFF; #1;
        check("comb_lane1_z", {63'h0, Zero}, 64'h0);
        // Combinational output ignores the clock entirely.
        @(negedge clk);

        // Register capture, then hold with in_valid low.
        A = 64'hAAAA_BBBB_CCCC_DDDD; B = 64'h1111_2222_3333_4444; in_valid = 1'b1;
        @(posedge clk); #1;
        check("cap_out_r",  Out_r, 64'h0000_2222_0000_4444);
        check("cap_zero_r", {63'h0, Zero_r},    64'h0);
        check("cap_valid",  {63'h0, out_valid}, 64'h1);
        in_valid = 1'b0; A = 64'hFFFF_0000_FFFF_0000; B = 64'h0F0F_0F0F_0F0F_0F0F;
        @(posedge clk); #1;
        check("hold_out_r", Out_r, 64'h0000_2222_0000_4444);
        check("hold_zero_r", {63'h0, Zero_r},   64'h0);
        check("hold_valid", {63'h0, out_valid}, 64'h0);
        check("hold_comb",  Out, 64'h0F0F_0000_0F0F_0000);

        // Back-to-back captures, including a zero result.
        A = 64'hFFFF_FFFF_0000_0000; B = 64'h0000_0000_FFFF_FFFF; in_valid = 1'b1;
        @(posedge clk); #1;
        check("b2b0_out_r",  Out_r, 64'h0);
        check("b2b0_zero_r", {63'h0, Zero_r},    64'h1);
        check("b2b0_valid",  {63'h0, out_valid}, 64'h1);
        A = 64'h1234_5678_9ABC_DEF0; B = 64'hFF00_FF00_FF00_FF00;
        @(posedge clk); #1;
        check("b2b1_out_r",  Out_r, 64'h1200_5600_9A00_DE00);
        check("b2b1_zero_r", {63'h0, Zero_r},    64'h0);
        check("b2b1_valid",  {63'h0, out_valid}, 64'h1);

        // Asynchronous reset between edges while a result is valid.
        A = 64'hFFFF_FFFF_FFFF_FFFF; B = 64'h0000_0000_0000_0001;
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_r",  Out_r, 64'h0);
        check("arst_zero_r", {63'h0, Zero_r},    64'h1);
        check("arst_valid",  {63'h0, out_valid}, 64'h0);
        check("arst_comb",   Out, 64'h1);
        // in_valid is still high across this edge: reset must win.
        @(posedge clk); #1;
        check("arst_win_r",  Out_r, 64'h0);
        check("arst_win_v",  {63'h0, out_valid}, 64'h0);

        @(negedge clk);
        rst = 1'b0;
        A = 64'h0000_FFFF_0000_FFFF; B = 64'h00FF_00FF_00FF_00FF;
        @(posedge clk); #1;
        check("rel_out_r",  Out_r, 64'h0000_00FF_0000_00FF);
        check("rel_zero_r", {63'h0, Zero_r},    64'h0);
        check("rel_valid",  {63'h0, out_valid}, 64'h1);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("rel_idle_v", {63'h0, out_valid}, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
